// File: rtl/l2cache_types_pkg.sv
// Shared types for the L2 way-state array: index/PLRU typedefs, flush FSM
// state encoding and the default geometry.
package l2cache_types_pkg;

    localparam int unsigned DEF_NUM_WAYS = 32'd4;
    localparam int unsigned DEF_NUM_SETS = 32'd32;
    localparam int unsigned DEF_WAY_W    = $clog2(DEF_NUM_WAYS);
    localparam int unsigned DEF_SET_W    = $clog2(DEF_NUM_SETS);

    typedef logic [DEF_WAY_W-1:0]    way_idx_t;
    typedef logic [DEF_SET_W-1:0]    set_idx_t;
    typedef logic [DEF_NUM_WAYS-2:0] plru_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/l2cache_plru_tree.sv
// Combinational tree pseudo-LRU: picks the victim way (invalid ways first)
// and computes the PLRU bits after touching a given way.
module l2cache_plru_tree #(
    parameter  int unsigned NUM_WAYS = 32'd4,
    localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] plru,
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [WAY_W-1:0]    touch_way,
    output logic [WAY_W-1:0]    victim_way,
    output logic [NUM_WAYS-2:0] plru_next
);

    logic [WAY_W-1:0] free_way_s;
    logic [WAY_W-1:0] tree_way_s;
    logic             any_free_s;

    // Lowest-indexed invalid way; scanning downwards lets the lowest win.
    always_comb begin
        free_way_s = {WAY_W{1'b0}};
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            free_way_s = valid[w] ? free_way_s : WAY_W'(w);
        end
    end

    assign any_free_s = ~(&valid);

    // Follow the PLRU pointers from the root; each node bit is also the next way bit.
    always_comb begin
        int   node_v;
        logic bit_v;
        node_v     = 0;
        bit_v      = 1'b0;
        tree_way_s = {WAY_W{1'b0}};
        for (int l = 0; l < int'(WAY_W); l++) begin
            bit_v      = plru[node_v];
            tree_way_s = (tree_way_s << 1) | WAY_W'(bit_v);
            node_v     = 2 * node_v + 1 + int'(bit_v);
        end
    end

    // Touch: every node on the path to touch_way points to the other half.
    always_comb begin
        int               node_v;
        logic             bit_v;
        logic [WAY_W-1:0] tw_v;
        node_v    = 0;
        bit_v     = 1'b0;
        tw_v      = touch_way;
        plru_next = plru;
        for (int l = 0; l < int'(WAY_W); l++) begin
            bit_v             = tw_v[WAY_W-1];
            plru_next[node_v] = ~bit_v;
            node_v            = 2 * node_v + 1 + int'(bit_v);
            tw_v              = tw_v << 1;
        end
    end

    assign victim_way = any_free_s ? free_way_s : tree_way_s;

endmodule

// File: rtl/l2cache_way_state_array.sv
// Per-set valid and tree-PLRU state for the L2 way arrays: victim selection,
// fill/hit/invalidate updates and a set-walking flush sequence.
module l2cache_way_state_array
    import l2cache_types_pkg::*;
#(
    parameter  int unsigned NUM_WAYS = DEF_NUM_WAYS,
    parameter  int unsigned NUM_SETS = DEF_NUM_SETS,
    localparam int unsigned SET_W    = $clog2(NUM_SETS),
    localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SET_W-1:0]    set_idx,
    input  logic                load_valid,
    input  logic                hit,
    input  logic [WAY_W-1:0]    hit_way,
    input  logic                inv,
    input  logic [WAY_W-1:0]    inv_way,
    input  logic                flush_req,
    output logic [NUM_WAYS-1:0] valid_out,
    output logic [WAY_W-1:0]    victim_way,
    output logic [NUM_WAYS-1:0] valid_load,
    output logic                ready,
    output logic                flush_done
);

    logic [NUM_WAYS-1:0] valid_r [NUM_SETS];
    logic [NUM_WAYS-2:0] plru_r  [NUM_SETS];
    state_t              state_r;
    state_t              state_nxt_s;
    logic [SET_W-1:0]    cnt_r;

    logic [NUM_WAYS-1:0] valid_set_s;
    logic [NUM_WAYS-1:0] valid_upd_s;
    logic [NUM_WAYS-1:0] onehot_s;
    logic [NUM_WAYS-2:0] plru_set_s;
    logic [NUM_WAYS-2:0] plru_touch_s;
    logic [NUM_WAYS-2:0] plru_upd_s;
    logic [WAY_W-1:0]    victim_s;
    logic [WAY_W-1:0]    touch_way_s;
    logic                accept_s;
    logic                upd_s;
    logic                last_set_s;
    logic                ready_s;
    logic                flush_done_s;

    assign valid_set_s = valid_r[set_idx];
    assign plru_set_s  = plru_r[set_idx];
    assign touch_way_s = load_valid ? victim_s : hit_way;

    l2cache_plru_tree #(
        .NUM_WAYS (NUM_WAYS)
    ) u_plru_tree (
        .plru       (plru_set_s),
        .valid      (valid_set_s),
        .touch_way  (touch_way_s),
        .victim_way (victim_s),
        .plru_next  (plru_touch_s)
    );

    assign onehot_s   = {{(NUM_WAYS-1){1'b0}}, 1'b1} << victim_s;
    assign accept_s   = (state_r == IDLE) && !flush_req;
    assign last_set_s = (cnt_r == SET_W'(NUM_SETS - 1));

    // Request decode: fill beats invalidate beats hit; a flush request drops all three.
    always_comb begin
        valid_upd_s = valid_set_s;
        plru_upd_s  = plru_set_s;
        upd_s       = 1'b0;
        if (accept_s) begin
            if (load_valid) begin
                valid_upd_s = valid_set_s | onehot_s;
                plru_upd_s  = plru_touch_s;
                upd_s       = 1'b1;
            end else if (inv) begin
                valid_upd_s[inv_way] = 1'b0;
                upd_s                = 1'b1;
            end else if (hit) begin
                plru_upd_s = plru_touch_s;
                upd_s      = 1'b1;
            end else begin
                upd_s = 1'b0;
            end
        end else begin
            upd_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = flush_req  ? FLUSH : IDLE;
            FLUSH:   state_nxt_s = last_set_s ? DONE  : FLUSH;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        ready_s      = 1'b0;
        flush_done_s = 1'b0;
        case (state_r)
            IDLE:    ready_s      = 1'b1;
            FLUSH:   ready_s      = 1'b0;
            DONE:    flush_done_s = 1'b1;
            default: ready_s      = 1'b0;
        endcase
    end

    // Flush set counter; holds at the last set instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {SET_W{1'b0}};
        end else if ((state_r == IDLE) && flush_req) begin
            cnt_r <= {SET_W{1'b0}};
        end else if ((state_r == FLUSH) && !last_set_s) begin
            cnt_r <= cnt_r + SET_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // State arrays: flush clears one set per cycle, otherwise the accepted request writes set_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                valid_r[s] <= {NUM_WAYS{1'b0}};
                plru_r[s]  <= {(NUM_WAYS-1){1'b0}};
            end
        end else if (state_r == FLUSH) begin
            valid_r[cnt_r] <= {NUM_WAYS{1'b0}};
            plru_r[cnt_r]  <= {(NUM_WAYS-1){1'b0}};
        end else if (upd_s) begin
            valid_r[set_idx] <= valid_upd_s;
            plru_r[set_idx]  <= plru_upd_s;
        end
    end

    assign valid_out  = valid_set_s;
    assign victim_way = victim_s;
    assign valid_load = (load_valid && ready_s) ? onehot_s : {NUM_WAYS{1'b0}};
    assign ready      = ready_s;
    assign flush_done = flush_done_s;

endmodule

// File: tb/tb_l2cache_way_state_array.sv
// Scoreboard bench for l2cache_way_state_array: 4-, 2- and 8-way instances
// share one stimulus bus; expectations are queued and checked on negedge.
module tb_l2cache_way_state_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sel;
    logic [4:0] set_idx;
    logic       load_valid;
    logic       hit;
    logic       inv;
    logic       flush_req;
    logic [2:0] hit_way;
    logic [2:0] inv_way;

    logic [3:0] vo4, vl4;
    logic [1:0] vw4;
    logic       rdy4, fd4;
    logic [1:0] vo2, vl2;
    logic [0:0] vw2;
    logic       rdy2, fd2;
    logic [7:0] vo8, vl8;
    logic [2:0] vw8;
    logic       rdy8, fd8;

    typedef struct {
        string      name;
        int         unit;
        logic [7:0] vo;
        logic [2:0] vw;
        logic [7:0] vl;
        logic       rdy;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    logic [7:0] a_vo, a_vl;
    logic [2:0] a_vw;
    logic       a_rdy, a_fd;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    l2cache_way_state_array #(.NUM_WAYS(4), .NUM_SETS(32)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_idx    (set_idx),
        .load_valid (load_valid && (sel == 2'd0)),
        .hit        (hit && (sel == 2'd0)),
        .hit_way    (hit_way[1:0]),
        .inv        (inv && (sel == 2'd0)),
        .inv_way    (inv_way[1:0]),
        .flush_req  (flush_req && (sel == 2'd0)),
        .valid_out  (vo4),
        .victim_way (vw4),
        .valid_load (vl4),
        .ready      (rdy4),
        .flush_done (fd4)
    );

    l2cache_way_state_array #(.NUM_WAYS(2), .NUM_SETS(32)) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_idx    (set_idx),
        .load_valid (load_valid && (sel == 2'd1)),
        .hit        (hit && (sel == 2'd1)),
        .hit_way    (hit_way[0:0]),
        .inv        (inv && (sel == 2'd1)),
        .inv_way    (inv_way[0:0]),
        .flush_req  (flush_req && (sel == 2'd1)),
        .valid_out  (vo2),
        .victim_way (vw2),
        .valid_load (vl2),
        .ready      (rdy2),
        .flush_done (fd2)
    );

    l2cache_way_state_array #(.NUM_WAYS(8), .NUM_SETS(32)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_idx    (set_idx),
        .load_valid (load_valid && (sel == 2'd2)),
        .hit        (hit && (sel == 2'd2)),
        .hit_way    (hit_way),
        .inv        (inv && (sel == 2'd2)),
        .inv_way    (inv_way),
        .flush_req  (flush_req && (sel == 2'd2)),
        .valid_out  (vo8),
        .victim_way (vw8),
        .valid_load (vl8),
        .ready      (rdy8),
        .flush_done (fd8)
    );

    // Monitor: pop each queued expectation and compare with the selected instance.
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            case (e.unit)
                0: begin
                    a_vo = {4'd0, vo4}; a_vw = {1'b0, vw4}; a_vl = {4'd0, vl4};
                    a_rdy = rdy4; a_fd = fd4;
                end
                1: begin
                    a_vo = {6'd0, vo2}; a_vw = {2'd0, vw2}; a_vl = {6'd0, vl2};
                    a_rdy = rdy2; a_fd = fd2;
                end
                default: begin
                    a_vo = vo8; a_vw = vw8; a_vl = vl8;
                    a_rdy = rdy8; a_fd = fd8;
                end
            endcase
            n_checks++;
            if (a_vo === e.vo && a_vw === e.vw && a_vl === e.vl &&
                a_rdy === e.rdy && a_fd === e.fd) begin
                n_pass++;
            end else begin
                $display("FAIL %s (unit %0d, set %0d) @%0t: got valid_out=%b victim=%0d valid_load=%b ready=%b flush_done=%b, want valid_out=%b victim=%0d valid_load=%b ready=%b flush_done=%b",
                         e.name, e.unit, set_idx, $time, a_vo, a_vw, a_vl, a_rdy, a_fd,
                         e.vo, e.vw, e.vl, e.rdy, e.fd);
            end
        end
    end

    // Watchdog: the run must finish well within this bound.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time @%0t", $time);
        $finish;
    end

    task automatic check_now(input string nm);
        n_checks++;
        if (vo4 === 4'h0 && vw4 === 2'd0 && rdy4 === 1'b1 && fd4 === 1'b0) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got valid_out=%b victim=%0d ready=%b flush_done=%b, want valid_out=0000 victim=0 ready=1 flush_done=0",
                     nm, $time, vo4, vw4, rdy4, fd4);
        end
    endtask

    task automatic op(input string nm, input int u, input int s, input int lv,
                      input int iv, input int iw, input int ht, input int hw,
                      input int fl, input int vo, input int vw, input int vl,
                      input int rdy, input int fd);
        exp_t x;
        sel        = 2'(u);
        set_idx    = 5'(s);
        load_valid = (lv != 0);
        inv        = (iv != 0);
        inv_way    = 3'(iw);
        hit        = (ht != 0);
        hit_way    = 3'(hw);
        flush_req  = (fl != 0);
        x.name = nm;
        x.unit = u;
        x.vo   = 8'(vo);
        x.vw   = 3'(vw);
        x.vl   = 8'(vl);
        x.rdy  = (rdy != 0);
        x.fd   = (fd != 0);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm, input int u, input int s, input int vo, input int vw);
        op(nm, u, s, 0, 0, 0, 0, 0, 0, vo, vw, 0, 1, 0);
    endtask

    task automatic fill(input string nm, input int u, input int s, input int vo,
                        input int vw, input int vl);
        op(nm, u, s, 1, 0, 0, 0, 0, 0, vo, vw, vl, 1, 0);
    endtask

    initial begin
        rst_n = 1'b0; sel = 2'd0; set_idx = 5'd0; load_valid = 1'b0; hit = 1'b0;
        inv = 1'b0; flush_req = 1'b0; hit_way = 3'd0; inv_way = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset asserted in the middle of activity
        fill("pre_rst_fill0", 0, 3, 8'h00, 0, 8'h01);
        fill("pre_rst_fill1", 0, 3, 8'h01, 1, 8'h02);
        rst_n = 1'b0;
        #1;
        check_now("rst_immediate");
        idle("rst_async", 0, 3, 8'h00, 0);
        rst_n = 1'b1;
        for (int s = 0; s < 32; s++) idle("rst_set_clear", 0, s, 8'h00, 0);

        // Invalid-first fill, PLRU touch, invalidate
        fill("fill_w0", 0, 5, 8'h00, 0, 8'h01);
        fill("fill_w1", 0, 5, 8'h01, 1, 8'h02);
        fill("fill_w2", 0, 5, 8'h03, 2, 8'h04);
        fill("fill_w3", 0, 5, 8'h07, 3, 8'h08);
        idle("set5_full", 0, 5, 8'h0F, 0);
        op("hit_w0", 0, 5, 0, 0, 0, 1, 0, 0, 8'h0F, 0, 8'h00, 1, 0);
        op("hit_w2", 0, 5, 0, 0, 0, 1, 2, 0, 8'h0F, 2, 8'h00, 1, 0);
        idle("after_hit_w2", 0, 5, 8'h0F, 1);
        op("inv_w1", 0, 5, 0, 1, 1, 0, 0, 0, 8'h0F, 1, 8'h00, 1, 0);
        idle("after_inv", 0, 5, 8'h0D, 1);
        fill("refill_w1", 0, 5, 8'h0D, 1, 8'h02);
        idle("plru_after_refill", 0, 5, 8'h0F, 3);

        // Same-cycle fill+inv+hit: only the fill applies
        fill("set7_w0", 0, 7, 8'h00, 0, 8'h01);
        op("prio_all", 0, 7, 1, 1, 0, 1, 3, 0, 8'h01, 1, 8'h02, 1, 0);
        idle("prio_result", 0, 7, 8'h03, 2);

        // Flush with load_valid held throughout
        fill("f_s0", 0, 0, 8'h00, 0, 8'h01);
        fill("f_s17", 0, 17, 8'h00, 0, 8'h01);
        fill("f_s31", 0, 31, 8'h00, 0, 8'h01);
        op("flush_req", 0, 0, 0, 0, 0, 0, 0, 1, 8'h01, 1, 8'h00, 1, 0);
        for (int i = 1; i <= 33; i++)
            op("flushing", 0, 31, 1, 0, 0, 0, 0, 0, (i <= 32) ? 1 : 0,
               (i <= 32) ? 1 : 0, 0, 0, (i == 33) ? 1 : 0);
        idle("flush_exit", 0, 31, 8'h00, 0);
        for (int s = 0; s < 32; s++) idle("flushed_set", 0, s, 8'h00, 0);

        // Reset while the flush counter is at 10
        fill("rf_s9", 0, 9, 8'h00, 0, 8'h01);
        fill("rf_s20", 0, 20, 8'h00, 0, 8'h01);
        op("rf_req", 0, 9, 0, 0, 0, 0, 0, 1, 8'h01, 1, 8'h00, 1, 0);
        for (int i = 1; i <= 10; i++)
            op("rf_flushing", 0, 9, 0, 0, 0, 0, 0, 0, 8'h01, 1, 8'h00, 0, 0);
        rst_n = 1'b0;
        #1;
        check_now("rf_rst_immediate");
        idle("rf_rst", 0, 20, 8'h00, 0);
        rst_n = 1'b1;
        for (int s = 0; s < 32; s++) idle("rf_set_clear", 0, s, 8'h00, 0);

        // Two-way instance
        fill("w2_fill0", 1, 5, 8'h00, 0, 8'h01);
        fill("w2_fill1", 1, 5, 8'h01, 1, 8'h02);
        idle("w2_full", 1, 5, 8'h03, 0);
        op("w2_hit0", 1, 5, 0, 0, 0, 1, 0, 0, 8'h03, 0, 8'h00, 1, 0);
        op("w2_hit1", 1, 5, 0, 0, 0, 1, 1, 0, 8'h03, 1, 8'h00, 1, 0);
        idle("w2_after_hit1", 1, 5, 8'h03, 0);
        fill("w2_lru0", 1, 5, 8'h03, 0, 8'h01);
        fill("w2_lru1", 1, 5, 8'h03, 1, 8'h02);
        idle("w2_lru_back", 1, 5, 8'h03, 0);

        // Eight-way instance
        for (int k = 0; k < 8; k++)
            fill("w8_fill", 2, 5, (1 << k) - 1, k, 1 << k);
        idle("w8_full", 2, 5, 8'hFF, 0);
        op("w8_hit0", 2, 5, 0, 0, 0, 1, 0, 0, 8'hFF, 0, 8'h00, 1, 0);
        op("w8_hit4", 2, 5, 0, 0, 0, 1, 4, 0, 8'hFF, 4, 8'h00, 1, 0);
        idle("w8_after_hit4", 2, 5, 8'hFF, 2);

        @(negedge clk);
        #1;
        if (n_pass != n_checks || n_checks < 12) begin
            $display("FAIL summary: %0d/%0d checks passed", n_pass, n_checks);
        end else begin
            $display("%0d/%0d checks passed", n_pass, n_checks);
        end
        $finish;
    end

endmodule

// File: doc/l2cache_way_state_array.md
Name: l2cache_way_state_array

Overview:
Parametrised N-way valid/replacement state store for the L2 cache, one entry per set.
- Holds per-way valid bits and tree pseudo-LRU bits for every set.
- Selects the victim way: invalid-first, otherwise PLRU.
- Generates the one-hot valid-load vector for the data/tag arrays.
- Runs a set-walking flush sequence.
- Sits between the L2 controller FSM and the way arrays; the single-bit lru / two-way valid-load path is the NUM_WAYS=2 case.

Parameters:
NUM_WAYS, 4, associativity; power of 2, >=2
NUM_SETS, 32, number of sets; power of 2, >=2
SET_W, $clog2(NUM_SETS), set index width (derived)
WAY_W, $clog2(NUM_WAYS), way index width (derived)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
set_idx  in  SET_W  set addressed this cycle by all requests and reads
load_valid  in  1  fill request: mark victim way valid, touch PLRU
hit  in  1  hit request: touch PLRU for hit_way
hit_way  in  WAY_W  way that hit
inv  in  1  invalidate request: clear valid of inv_way
inv_way  in  WAY_W  way to invalidate
flush_req  in  1  start full flush
valid_out  out  NUM_WAYS  valid bits of set_idx
victim_way  out  WAY_W  replacement choice for set_idx
valid_load  out  NUM_WAYS  one-hot load strobe for the victim way
ready  out  1  high when IDLE and requests are accepted
flush_done  out  1  one-cycle pulse at flush end

Behaviour:
Storage:
- Flop arrays: valid[NUM_SETS][NUM_WAYS] and plru[NUM_SETS][NUM_WAYS-1].

Combinational reads (zero latency):
- valid_out and victim_way are derived from the set_idx entry.
- Victim: lowest-indexed invalid way if any; else walk the tree from node 0. At node n, bit=0 goes to child 2n+1 (lower half), bit=1 goes to 2n+2. Leaf node L maps to way L-(NUM_WAYS-1).
- valid_load = onehot(victim_way) when load_valid && ready, else 0.

Requests:
- Accepted only when ready=1. All updates take effect on the next rising edge.
- Exactly one operation per cycle. Priority: load_valid > inv > hit; lower-priority requests in the same cycle are dropped.
- Fill: valid[set][victim]=1; touch(victim).
- Hit: touch(hit_way); valid unchanged. A hit on an invalid way is still a touch.
- Inv: valid[set][inv_way]=0; PLRU unchanged.
- touch(w): every node on the root-to-leaf path of w is set to point away from w. Going to the lower child sets the bit to 1; going to the upper child sets it to 0.

FSM:
- States: IDLE, FLUSH, DONE.
- IDLE: ready=1. flush_req -> FLUSH with cnt=0. flush_req takes priority over a same-cycle request, which is dropped.
- FLUSH: ready=0. Each cycle clears valid[cnt] and plru[cnt] to 0. At cnt==NUM_SETS-1 -> DONE, else cnt++.
- cnt is SET_W wide, with no wrap past the last set.
- DONE: flush_done=1 for one cycle -> IDLE.
- Flush occupancy is NUM_SETS cycles in FLUSH plus 1 in DONE.
- flush_req in FLUSH or DONE is ignored.
- valid_out and victim_way stay readable during flush. valid_load is forced to 0.

Reset (async assert, any state, including mid-flush):
- All valid and plru bits 0, state IDLE, cnt 0.
- Outputs: ready=1, flush_done=0, valid_load=0, valid_out=0, victim_way=0.
- Deassertion is synchronised upstream; the block adds nothing.

NUM_WAYS=2 equivalence:
- One PLRU bit per set. valid_load = {load_valid&lru, load_valid&~lru} once both ways are valid.

Decomposition:
- Package l2cache_types_pkg holds: typedef way_idx_t (logic [WAY_W-1:0]), set_idx_t, plru_t (logic [NUM_WAYS-2:0]), the state enum {IDLE, FLUSH, DONE}, and the default NUM_WAYS/NUM_SETS localparams.
- One natural sub-module, l2cache_plru_tree: a purely combinational, NUM_WAYS-parametrised block. Inputs: plru bits, valid bits, touch way. Outputs: victim way and next plru bits.
- The top level keeps the arrays, priority logic, FSM and counter.

Test Plan:
1. Reset: hold rst_n=0 mid-operation, release -> valid_out=0000, victim_way=0, ready=1, flush_done=0 for every set_idx.
2. Invalid-first fill: set_idx=5, four cycles of load_valid -> valid_load=0001, 0010, 0100, 1000 in turn; valid_out=1111. Then victim_way=0 (plru root=0, node1=0, node2=0).
3. PLRU touch: continue from 2; hit, hit_way=0 -> victim_way=2. Then hit, hit_way=2 -> victim_way=1.
4. Invalidate and priority: set 5 full; inv, inv_way=1 -> valid_out=1101, victim_way=1. Same cycle load_valid+inv+hit on set 7 -> only the fill applies; valid[7] gains the victim bit and inv_way stays untouched.
5. Flush: fill sets 0, 17 and 31, then pulse flush_req -> ready=0 for 33 cycles, flush_done high exactly in cycle 33 after the request, then all sets valid_out=0. A load_valid during flush -> valid_load=0 and no state change.
6. Reset mid-flush: assert rst_n=0 at cnt=10 -> ready=1 immediately, no flush_done pulse, all sets invalid. Repeat scenarios 2-3 with NUM_WAYS=2 and NUM_WAYS=8.
